text_console: RTL and testbench

Parametrised text-mode character buffer and cursor engine. It accepts a stream of ASCII codes from the keyboard/lookup path, maintains a cursor, and interprets newline and backspace. When the cursor runs off the bottom row, it scrolls by rotating a row offset and blanking the new bottom row. The VGA font renderer reads characters through a registered port addressed in logical (on-screen) coordinates.

---
 rtl/text_console_pkg.sv | 20 ++
 rtl/text_console_if.sv | 23 ++
 rtl/text_console_char_ram.sv | 28 ++
 rtl/text_console.sv | 226 ++++++++++++++++++++++
 tb/tb_text_console.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console.
package console_pkg;

  localparam logic [7:0] ASC_LF       = 8'h0A;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_SP       = 8'h20;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SCROLL = 2'd2
  } con_state_e;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASC_PRINT_LO) && (code <= ASC_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Keyboard code stream handshake plus the screen-clear request.
interface text_console_if;

  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic       clear_req;

  modport master (
    output key_valid,
    output key_ascii,
    output clear_req,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_ascii,
    input  clear_req,
    output key_ready
  );

endinterface

// File: rtl/text_console_char_ram.sv
// Character store: one synchronous write port, one registered read port, no array reset.
module char_ram #(
  parameter int DEPTH = 2130,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/text_console.sv
// Text-mode character buffer with cursor, newline/backspace handling and
// scrolling by rotating a physical row offset.
module text_console
  import console_pkg::*;
#(
  parameter int  COLS = 71,
  parameter int  ROWS = 30,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS),
  localparam int AW   = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          resetn,
  text_console_if.slave kbd,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          busy
);

  localparam int            CELLS     = COLS * ROWS;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  con_state_e    state_r, state_n;
  logic [AW-1:0] clr_idx_r, clr_idx_n;
  logic [RW-1:0] top_r, top_n;
  logic [CW-1:0] cur_col_r, cur_col_n;
  logic [RW-1:0] cur_row_r, cur_row_n;
  logic [CW-1:0] blank_col_r, blank_col_n;
  logic          rd_oob_r;

  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [7:0]    wdata_s;
  logic [AW-1:0] raddr_s;
  logic          rd_oob_s;
  logic [7:0]    ram_q_s;
  logic [RW-1:0] top_wrap_s;

  // Logical (row, col) to RAM address; the add-and-subtract avoids a divider.
  function automatic logic [AW-1:0] map_addr(input logic [RW-1:0] lrow,
                                             input logic [CW-1:0] col,
                                             input logic [RW-1:0] top);
    logic [RW:0]   sum;
    logic [RW-1:0] prow;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (RW+1)'(ROWS)) begin
      prow = RW'(sum - (RW+1)'(ROWS));
    end else begin
      prow = sum[RW-1:0];
    end
    return (AW'(prow) * AW'(COLS)) + AW'(col);
  endfunction

  assign kbd.key_ready = (state_r == ST_IDLE) && !kbd.clear_req;
  assign busy          = (state_r != ST_IDLE);
  assign cursor_col    = cur_col_r;
  assign cursor_row    = cur_row_r;
  assign top_wrap_s    = (top_r == ROW_LAST) ? {RW{1'b0}} : (top_r + RW'(1));

  // next-state, cursor and write-port decode
  always_comb begin
    state_n     = state_r;
    clr_idx_n   = clr_idx_r;
    top_n       = top_r;
    cur_col_n   = cur_col_r;
    cur_row_n   = cur_row_r;
    blank_col_n = blank_col_r;
    we_s        = 1'b0;
    waddr_s     = {AW{1'b0}};
    wdata_s     = ASC_SP;
    case (state_r)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = clr_idx_r;
        if (clr_idx_r == LAST_CELL) begin
          state_n   = ST_IDLE;
          clr_idx_n = {AW{1'b0}};
        end else begin
          clr_idx_n = clr_idx_r + AW'(1);
        end
      end
      ST_IDLE: begin
        if (kbd.clear_req) begin
          state_n     = ST_CLEAR;
          clr_idx_n   = {AW{1'b0}};
          top_n       = {RW{1'b0}};
          cur_col_n   = {CW{1'b0}};
          cur_row_n   = {RW{1'b0}};
          blank_col_n = {CW{1'b0}};
        end else if (kbd.key_valid) begin
          if (is_printable(kbd.key_ascii)) begin
            // the character lands at the old offset even if it triggers a scroll
            we_s    = 1'b1;
            waddr_s = map_addr(cur_row_r, cur_col_r, top_r);
            wdata_s = kbd.key_ascii;
            if (cur_col_r != COL_LAST) begin
              cur_col_n = cur_col_r + CW'(1);
            end else if (cur_row_r != ROW_LAST) begin
              cur_col_n = {CW{1'b0}};
              cur_row_n = cur_row_r + RW'(1);
            end else begin
              state_n     = ST_SCROLL;
              top_n       = top_wrap_s;
              cur_col_n   = {CW{1'b0}};
              cur_row_n   = ROW_LAST;
              blank_col_n = {CW{1'b0}};
            end
          end else if (kbd.key_ascii == ASC_LF) begin
            cur_col_n = {CW{1'b0}};
            if (cur_row_r != ROW_LAST) begin
              cur_row_n = cur_row_r + RW'(1);
            end else begin
              state_n     = ST_SCROLL;
              top_n       = top_wrap_s;
              cur_row_n   = ROW_LAST;
              blank_col_n = {CW{1'b0}};
            end
          end else if (kbd.key_ascii == ASC_BS) begin
            if (cur_col_r != {CW{1'b0}}) begin
              cur_col_n = cur_col_r - CW'(1);
              we_s      = 1'b1;
              waddr_s   = map_addr(cur_row_r, cur_col_r - CW'(1), top_r);
            end else if (cur_row_r != {RW{1'b0}}) begin
              cur_col_n = COL_LAST;
              cur_row_n = cur_row_r - RW'(1);
              we_s      = 1'b1;
              waddr_s   = map_addr(cur_row_r - RW'(1), COL_LAST, top_r);
            end else begin
              cur_col_n = cur_col_r;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SCROLL: begin
        if (kbd.clear_req) begin
          state_n     = ST_CLEAR;
          clr_idx_n   = {AW{1'b0}};
          top_n       = {RW{1'b0}};
          cur_col_n   = {CW{1'b0}};
          cur_row_n   = {RW{1'b0}};
          blank_col_n = {CW{1'b0}};
        end else begin
          // top_r already rotated, so logical bottom row is the one to blank
          we_s    = 1'b1;
          waddr_s = map_addr(ROW_LAST, blank_col_r, top_r);
          if (blank_col_r == COL_LAST) begin
            state_n     = ST_IDLE;
            blank_col_n = {CW{1'b0}};
          end else begin
            blank_col_n = blank_col_r + CW'(1);
          end
        end
      end
      default: begin
        state_n     = ST_CLEAR;
        clr_idx_n   = {AW{1'b0}};
        top_n       = {RW{1'b0}};
        cur_col_n   = {CW{1'b0}};
        cur_row_n   = {RW{1'b0}};
        blank_col_n = {CW{1'b0}};
      end
    endcase
  end

  // state, offset and cursor registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_CLEAR;
      clr_idx_r   <= {AW{1'b0}};
      top_r       <= {RW{1'b0}};
      cur_col_r   <= {CW{1'b0}};
      cur_row_r   <= {RW{1'b0}};
      blank_col_r <= {CW{1'b0}};
    end else begin
      state_r     <= state_n;
      clr_idx_r   <= clr_idx_n;
      top_r       <= top_n;
      cur_col_r   <= cur_col_n;
      cur_row_r   <= cur_row_n;
      blank_col_r <= blank_col_n;
    end
  end

  // Read address decode; out-of-range coordinates bypass the RAM and show a space.
  always_comb begin
    rd_oob_s = ({1'b0, rd_col} >= (CW+1)'(COLS)) || ({1'b0, rd_row} >= (RW+1)'(ROWS));
    if (rd_oob_s) begin
      raddr_s = {AW{1'b0}};
    end else begin
      raddr_s = map_addr(rd_row, rd_col, top_r);
    end
  end

  // out-of-range flag travels alongside the RAM read stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_oob_r <= 1'b1;
    end else begin
      rd_oob_r <= rd_oob_s;
    end
  end

  assign rd_data = rd_oob_r ? ASC_SP : ram_q_s;

  char_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_char_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (ram_q_s)
  );

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: vector table, read scoreboard and
// hand-written scroll/clear/reset sequences.
module tb_text_console;
  import console_pkg::*;

  localparam int CW = 7;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [7:0]    rd_data;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic          busy;

  text_console_if kif();

  text_console dut (
    .clk        (clk),
    .resetn     (resetn),
    .kbd        (kif),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         is_key;
    logic [7:0] code;
    int         col;
    int         row;
    logic [7:0] exp_d;
    int         exp_cc;
    int         exp_cr;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cursor(input string nm, input int c, input int r);
    chk({nm, "_col"}, 32'(cursor_col), 32'(c));
    chk({nm, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_key(input logic [7:0] code);
    int n;
    kif.key_valid = 1'b1;
    kif.key_ascii = code;
    n = 0;
    while (!kif.key_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("key_ready_timeout", 32'(n), 32'(0));
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  // called at a negedge; expected value goes to the scoreboard, popped when data is due
  task automatic rd_check(input int c, input int r, input logic [7:0] e, input string nm);
    logic [7:0] ev;
    rd_col = 7'(c);
    rd_row = 5'(r);
    exp_q.push_back(e);
    @(negedge clk);
    ev = exp_q.pop_front();
    chk(nm, 32'(rd_data), 32'(ev));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'(1));
    chk({nm, "_ready"}, 32'(kif.key_ready), 32'(0));
    chk_cursor(nm, 0, 0);
    chk({nm, "_rd_data"}, 32'(rd_data), 32'(8'h20));
  endtask

  initial begin
    int n;
    kif.key_valid = 1'b0;
    kif.key_ascii = 8'h00;
    kif.clear_req = 1'b0;
    rd_col = 7'd3;
    rd_row = 5'd2;

    vt[0] = '{1'b0, 8'h00, 0, 0, 8'h20, 0, 0};
    vt[1] = '{1'b0, 8'h00, 70, 29, 8'h20, 0, 0};
    vt[2] = '{1'b0, 8'h00, 75, 31, 8'h20, 0, 0};
    vt[3] = '{1'b1, 8'h41, 0, 0, 8'h00, 1, 0};
    vt[4] = '{1'b1, 8'h42, 0, 0, 8'h00, 2, 0};
    vt[5] = '{1'b0, 8'h00, 0, 0, 8'h41, 0, 0};
    vt[6] = '{1'b0, 8'h00, 1, 0, 8'h42, 0, 0};
    vt[7] = '{1'b1, 8'h07, 0, 0, 8'h00, 2, 0};
    vt[8] = '{1'b1, 8'h00, 0, 0, 8'h00, 2, 0};
    vt[9] = '{1'b0, 8'h00, 2, 0, 8'h20, 0, 0};

    repeat (3) @(negedge clk);
    reset_checks("reset");
    resetn = 1'b1;
    count_busy(n);
    chk("clear_cycles", 32'(n), 32'(2130));
    chk("ready_after_clear", 32'(kif.key_ready), 32'(1));
    chk_cursor("home", 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_key) begin
        send_key(vt[i].code);
        chk_cursor($sformatf("vec%0d", i), vt[i].exp_cc, vt[i].exp_cr);
      end else begin
        rd_check(vt[i].col, vt[i].row, vt[i].exp_d, $sformatf("vec%0d_rd", i));
      end
    end

    // backspace back to home, then backspace at home is a no-op
    send_key(ASC_BS);
    send_key(ASC_BS);
    chk_cursor("bs_home", 0, 0);
    rd_check(0, 0, 8'h20, "bs_erased");
    send_key(ASC_BS);
    chk_cursor("bs_noop", 0, 0);

    // fill row 0 and wrap, then backspace across the row boundary
    for (int i = 0; i < 71; i++) send_key(8'h58);
    chk_cursor("wrap", 0, 1);
    rd_check(70, 0, 8'h58, "row0_last");
    rd_check(0, 0, 8'h58, "row0_first");
    send_key(ASC_BS);
    chk_cursor("bs_wrap", 70, 0);
    rd_check(70, 0, 8'h20, "bs_wrap_erased");
    rd_check(69, 0, 8'h58, "bs_wrap_kept");

    // mark row 1, walk to the bottom, then force a scroll
    send_key(ASC_LF);
    send_key(8'h4D);
    for (int i = 0; i < 28; i++) send_key(ASC_LF);
    chk_cursor("bottom", 0, 29);
    send_key(8'h5A);
    chk_cursor("z_typed", 1, 29);
    send_key(ASC_LF);
    count_busy(n);
    chk("scroll_cycles", 32'(n), 32'(71));
    chk_cursor("after_scroll", 0, 29);
    rd_check(0, 28, 8'h5A, "z_moved_up");
    rd_check(0, 0, 8'h4D, "row1_now_row0");
    rd_check(1, 0, 8'h20, "row0_col1");
    for (int c = 0; c < 71; c++) rd_check(c, 29, 8'h20, $sformatf("bottom_blank%0d", c));

    // clear_req wins over a key while scrolling
    send_key(ASC_LF);
    repeat (10) @(negedge clk);
    chk("mid_scroll_busy", 32'(busy), 32'(1));
    kif.clear_req = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_ascii = 8'h41;
    chk("ready_during_clear_req", 32'(kif.key_ready), 32'(0));
    @(negedge clk);
    kif.clear_req = 1'b0;
    kif.key_valid = 1'b0;
    count_busy(n);
    chk("clear_req_cycles", 32'(n), 32'(2130));
    chk_cursor("after_clear", 0, 0);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 71; c++)
        rd_check(c, r, 8'h20, $sformatf("cleared_%0d_%0d", c, r));

    // clear must leave an unrotated screen: typed text reads back at its own place
    send_key(8'h51);
    for (int i = 0; i < 29; i++) send_key(ASC_LF);
    send_key(8'h52);
    rd_check(0, 0, 8'h51, "post_clear_top");
    rd_check(0, 29, 8'h52, "post_clear_bottom");

    // reset in the middle of a scroll
    send_key(ASC_LF);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    reset_checks("mid_scroll_reset");
    resetn = 1'b1;
    count_busy(n);
    chk("reclear_cycles", 32'(n), 32'(2130));
    chk_cursor("reclear_home", 0, 0);
    rd_check(0, 0, 8'h20, "reclear_cell");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
